gbuff_drain: RTL and testbench
==============================

GBUFF_DRAIN -- requirements
Module: gbuff_drain

Interface
REQ-001 Parameter IDX_W, default 32, width of the global buffer index bus.
REQ-002 Parameter WORD_W, default 32, width of one global buffer word.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  one-cycle request to begin a drain; sampled only in IDLE.
REQ-007 base_idx  input  IDX_W  index of the first word to read.
REQ-008 num_words  input  9  word count, 0..256; sampled with start.
REQ-009 gb_wr_en  output  1  global buffer write enable; constant 0.
REQ-010 gb_index  output  IDX_W  global buffer read index.
REQ-011 gb_rdata  input  WORD_W  global buffer read data; valid one cycle after gb_index is presented (registered read).
REQ-012 m_valid  output  1  stream word valid.
REQ-013 m_ready  input  1  downstream accepts the word.
REQ-014 m_data  output  WORD_W  stream word.
REQ-015 m_last  output  1  high with the final word of a drain.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 done  output  1  one-cycle completion pulse.

Function
REQ-018 FSM states: IDLE, READ, FLUSH, FIN.
- IDLE to READ on start with num_words>0.
- IDLE to FIN on start with num_words==0.
- READ to FLUSH after the last read is issued.
- FLUSH to FIN on the handshake of the last word.
- FIN to IDLE unconditionally after one cycle.
REQ-019 done is high only in FIN, for exactly one cycle.
REQ-020 start outside IDLE is ignored, and base_idx and num_words are not re-sampled.
REQ-021 Read issue: in READ, gb_index = base_idx + issued_count, taken modulo 2^IDX_W; the index wraps silently past all-ones.
REQ-022 A read issues in a cycle only if (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready in that cycle.
REQ-023 Outside a cycle that issues a read, gb_index holds its last value.
REQ-024 Output buffering: a 2-entry FIFO is written with gb_rdata one cycle after each issued read; it never overflows.
REQ-025 m_valid = FIFO not empty; m_data = FIFO head.
REQ-026 While m_valid & !m_ready, m_data and m_last hold stable.
REQ-027 Throughput: with m_ready held high, one word is transferred per cycle, with no bubbles after the first word.
REQ-028 Latency: start is sampled at edge E0 and the first read index is presented after E0. m_valid first rises after E0+2.
REQ-029 m_last is high exactly when the head word is word num_words-1.
REQ-030 Words are emitted in index order with none dropped or duplicated, independent of the m_ready pattern.
REQ-031 num_words==0: no reads, no m_valid, done pulses the cycle after start.
REQ-032 num_words==256: exactly 256 words are emitted, and issued_count and emitted_count are held at 9 bits.

Reset
REQ-033 Asserting rst forces IDLE immediately and clears the FIFO, inflight, and both counters, including mid-drain.
REQ-034 During reset, m_valid, m_last, busy, and done are 0, and gb_index and m_data are 0.
REQ-035 After rst deasserts, no stale word appears and operation resumes only on a new start.

Verification
REQ-036 start, base_idx=0, num_words=4, m_ready=1, buffer words 10..13 -> m_valid from E0+2 for 4 consecutive cycles with data 10,11,12,13. m_last is set on 13, done pulses on the next cycle, and busy falls with it.
REQ-037 num_words=8, m_ready toggling 1,0,0,1 -> all 8 words arrive in order, m_data is stable during each stall, and there are never more than 2 reads outstanding plus queued.
REQ-038 base_idx=all-ones, num_words=3 -> gb_index sequence is all-ones, 0, 1, and 3 words are emitted.
REQ-039 num_words=0 -> done pulses at E0+1, m_valid stays 0, and gb_index does not change.
REQ-040 rst asserted after 2 of 6 words with m_ready=0 -> outputs clear asynchronously. After release, a fresh drain with num_words=2 emits exactly 2 words and no stale data.
REQ-041 start pulsed again while busy -> it is ignored, and the current drain completes unchanged with a single done pulse.

Source files
------------

// File: rtl/gbuff_drain.sv
// Drains a contiguous range of a registered-read global buffer into a
// ready/valid stream through a 2-entry skid FIFO, one word per cycle at best.
module gbuff_drain #(
  parameter int IDX_W  = 32,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [IDX_W-1:0]  base_idx,
  input  logic [8:0]        num_words,
  output logic              gb_wr_en,
  output logic [IDX_W-1:0]  gb_index,
  input  logic [WORD_W-1:0] gb_rdata,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_FLUSH,
    S_FIN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W-1:0]  r_base;
  logic [IDX_W-1:0]  r_last_idx;
  logic [8:0]        r_num;
  logic [8:0]        r_issued;
  logic [8:0]        r_emitted;
  logic              r_inflight;
  logic [WORD_W-1:0] r_fifo [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;

  logic              w_pop;
  logic              w_issue;
  logic              w_start_ok;
  logic [1:0]        w_occ;
  logic [IDX_W-1:0]  w_rd_idx;

  assign w_pop      = m_valid & m_ready;
  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_occ      = r_count + {1'b0, r_inflight};
  assign w_rd_idx   = r_base + IDX_W'(r_issued);
  // A word popped this cycle frees its slot for the read issued in the same cycle.
  assign w_issue    = (r_state == S_READ) &&
                      ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop));

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = (num_words == 9'd0) ? S_FIN : S_READ;
      S_READ:  if (w_issue && (r_issued + 9'd1 == r_num)) w_state_nxt = S_FLUSH;
      S_FLUSH: if (w_pop && m_last) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_num      <= '0;
      r_issued   <= '0;
      r_emitted  <= '0;
      r_last_idx <= '0;
      r_inflight <= 1'b0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_inflight <= w_issue;
      if (w_start_ok) begin
        r_base    <= base_idx;
        r_num     <= num_words;
        r_issued  <= '0;
        r_emitted <= '0;
      end else begin
        if (w_issue) r_issued  <= r_issued + 9'd1;
        if (w_pop)   r_emitted <= r_emitted + 9'd1;
      end
      if (w_issue)    r_last_idx <= w_rd_idx;
      if (r_inflight) r_wr_ptr   <= ~r_wr_ptr;
      if (w_pop)      r_rd_ptr   <= ~r_rd_ptr;
      r_count <= 2'(r_count + {1'b0, r_inflight} - {1'b0, w_pop});
    end
  end

  // NOTE: the FIFO storage is reset because m_data must read as zero while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fifo[0] <= '0;
      r_fifo[1] <= '0;
    end else if (r_inflight) begin
      r_fifo[r_wr_ptr] <= gb_rdata;
    end
  end

  assign gb_wr_en = 1'b0;
  assign gb_index = w_issue ? w_rd_idx : r_last_idx;
  assign m_valid  = (r_count != 2'd0);
  assign m_data   = r_fifo[r_rd_ptr];
  assign m_last   = m_valid && (r_emitted == r_num - 9'd1);
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_FIN);

endmodule

// File: tb/tb_gbuff_drain.sv
// Bench for gbuff_drain: a registered-read buffer model, a ready driver and a
// monitor that compares the stream against the expected index-ordered words.
module tb_gbuff_drain;

  localparam int IDX_W  = 32;
  localparam int WORD_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [IDX_W-1:0]  base_idx;
  logic [8:0]        num_words;
  logic              gb_wr_en;
  logic [IDX_W-1:0]  gb_index;
  logic [WORD_W-1:0] gb_rdata;
  logic              m_valid;
  logic              m_ready;
  logic [WORD_W-1:0] m_data;
  logic              m_last;
  logic              busy;
  logic              done;

  gbuff_drain #(.IDX_W(IDX_W), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_idx(base_idx), .num_words(num_words),
    .gb_wr_en(gb_wr_en), .gb_index(gb_index), .gb_rdata(gb_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] salt_x = 32'd0;
  logic [31:0] salt_a = 32'd10;
  logic [31:0] idx_smp = 32'd0;
  logic [31:0] exp_base = 32'd0;
  int          exp_n = 0;
  int          ready_mode = 0;
  int          drain_id = 0;
  bit          mon_en = 1'b0;

  int          rcv_cnt = 0;
  int          iss_cnt = 0;
  int          done_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] idx);
    return (idx ^ salt_x) + salt_a;
  endfunction

  // Buffer model (data one cycle after the index) and downstream ready pattern.
  initial begin : drv
    int rcyc;
    rcyc     = 0;
    m_ready  = 1'b1;
    gb_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      gb_rdata = mem_word(idx_smp);
      rcyc++;
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((rcyc % 4) == 0) || ((rcyc % 4) == 3);
        2:       m_ready = ($urandom_range(0, 3) != 0);
        3:       m_ready = 1'b0;
        default: m_ready = (rcv_cnt < 2);
      endcase
    end
  end

  // Stream monitor: order, last flag, stall stability and read occupancy.
  initial begin : mon
    int   seen_id;
    bit   stall_prev;
    bit   pop;
    logic [31:0] prev_data;
    logic prev_last;
    seen_id    = 0;
    stall_prev = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      idx_smp = gb_index;
      if (mon_en) begin
        if (seen_id != drain_id) begin
          seen_id    = drain_id;
          rcv_cnt    = 0;
          iss_cnt    = 0;
          done_cnt   = 0;
          stall_prev = 1'b0;
        end
        if (busy && (iss_cnt < exp_n) && (gb_index === exp_base + 32'(iss_cnt))) iss_cnt++;
        pop = m_valid && m_ready;
        if (busy) check("outstanding_le2", (iss_cnt - rcv_cnt - int'(pop)) <= 2, 1);
        if (stall_prev) begin
          check("stall_valid", m_valid, 1);
          check("stall_data", m_data, prev_data);
          check("stall_last", m_last, prev_last);
        end
        if (pop) begin
          check("word_count_bound", rcv_cnt < exp_n, 1);
          if (rcv_cnt < exp_n) begin
            check("word_data", m_data, mem_word(exp_base + 32'(rcv_cnt)));
            check("word_last", m_last, rcv_cnt == exp_n - 1);
          end
          rcv_cnt++;
        end
        if (!busy && m_valid) check("valid_while_idle", m_valid, 0);
        if (done) done_cnt++;
        stall_prev = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  task automatic run_drain(input logic [31:0] b, input int n, input int mode, input bit inject,
                           output int done_cyc, output int first_v);
    int cyc;
    ready_mode = mode;
    exp_base   = b;
    exp_n      = n;
    drain_id++;
    mon_en     = 1'b1;
    @(negedge clk);
    start     = 1'b1;
    base_idx  = b;
    num_words = 9'(n);
    @(negedge clk);
    start     = 1'b0;
    base_idx  = $urandom;
    num_words = 9'($urandom_range(0, 256));
    cyc     = 1;
    first_v = -1;
    check("busy_after_start", busy, 1);
    while (!done && cyc < 4 * n + 40) begin
      if (m_valid && first_v < 0) first_v = cyc;
      start = inject && (cyc == 3);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    done_cyc = cyc;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_clear", busy, 0);
    @(negedge clk);
    check("words_received", rcv_cnt, n);
    check("reads_issued", iss_cnt, n);
    check("done_pulses", done_cnt, 1);
  endtask

  initial begin : stim
    int dc;
    int fv;
    int n;
    int mode;
    int cnt;
    logic [31:0] b;
    logic [31:0] prev_idx;
    rst       = 1'b0;
    start     = 1'b0;
    base_idx  = '0;
    num_words = '0;
    repeat (3) @(negedge clk);
    check("rst_valid", m_valid, 0);
    check("rst_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_index", gb_index, 0);
    check("rst_data", m_data, 0);
    check("wr_en_zero", gb_wr_en, 0);
    rst = 1'b1;
    @(negedge clk);

    // Basic drain of words 10..13 at full rate.
    run_drain(32'd0, 4, 0, 1'b0, dc, fv);
    check("first_valid_cyc", fv, 3);
    check("done_cyc", dc, 7);

    // Stalling consumer with a 1,0,0,1 ready pattern.
    salt_x = $urandom;
    salt_a = $urandom;
    run_drain($urandom, 8, 1, 1'b0, dc, fv);

    // Index wraps past all-ones.
    run_drain(32'hFFFF_FFFF, 3, 0, 1'b0, dc, fv);
    check("wrap_done_cyc", dc, 6);

    // Empty drain: no reads, no data, immediate done.
    prev_idx = gb_index;
    run_drain($urandom, 0, 0, 1'b0, dc, fv);
    check("zero_done_cyc", dc, 1);
    check("zero_no_valid", fv < 0, 1);
    check("zero_index_held", gb_index, prev_idx);

    // A second start while busy must be ignored.
    run_drain($urandom, 10, 0, 1'b1, dc, fv);
    check("inject_done_cyc", dc, 13);

    // Randomized drains, some near the index wrap point.
    for (int i = 0; i < 10; i++) begin
      salt_x = $urandom;
      salt_a = $urandom;
      n      = $urandom_range(1, 24);
      mode   = $urandom_range(0, 2);
      b      = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
      run_drain(b, n, mode, 1'b0, dc, fv);
      if (mode == 0) check("throughput", dc - fv, n);
    end

    // Maximum count, random and full-rate consumers.
    run_drain($urandom, 256, 2, 1'b0, dc, fv);
    run_drain($urandom, 256, 0, 1'b0, dc, fv);
    check("max_done_cyc", dc, 259);

    // Reset mid-drain after two words with the consumer stalled.
    b          = $urandom;
    ready_mode = 4;
    exp_base   = b;
    exp_n      = 6;
    drain_id++;
    mon_en     = 1'b1;
    @(negedge clk);
    start     = 1'b1;
    base_idx  = b;
    num_words = 9'd6;
    @(negedge clk);
    start = 1'b0;
    cnt   = 0;
    while (rcv_cnt < 2 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    repeat (3) @(negedge clk);
    check("pre_reset_valid", m_valid, 1);
    check("words_before_reset", rcv_cnt, 2);
    mon_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("arst_valid", m_valid, 0);
    check("arst_last", m_last, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_index", gb_index, 0);
    check("arst_data", m_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst        = 1'b1;
    ready_mode = 0;
    repeat (4) begin
      @(negedge clk);
      check("no_stale_valid", m_valid, 0);
      check("idle_after_reset", busy, 0);
    end
    run_drain($urandom, 2, 0, 1'b0, dc, fv);
    check("post_reset_done_cyc", dc, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
